n64_poll_sender: RTL and testbench
==================================

# n64_poll_sender

Console-side transmitter in front of `n64_read_controller` on the N64 controller data line. On request or on a periodic timer, it serialises an 8-bit command (default 0x01, poll buttons) plus a stop bit using N64 pulse-width encoding. It drives the line through an open-drain control signal, then releases the line and asserts `read_enable` for a bounded response window. The reader samples the controller's 32-bit reply during that window.

## Interface
- `US_CYCLES`, default 100: clock cycles per microsecond; must be ≥ 2.
- `CMD_BYTE`, default 8'h01: command sent, MSB first.
- `RESP_US`, default 160: response window length in µs.
- `POLL_US`, default 16667: auto-poll period in µs. Used only with `N64_POLL_AUTO_EN`.
- `clock` input 1: system clock, all logic on the rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `start` input 1: single-cycle poll request, honoured only in IDLE.
- `auto_en` input 1: enable periodic polling.
- `line_in` input 1: raw data-line level; synchronised internally with 2 flops.
- `drive_low` output 1: 1 = pull the line low (tristate buffer enable); 0 = released.
- `busy` output 1: high in every state except IDLE.
- `read_enable` output 1: high during the response window; drives the reader's `enable`.
- `line_err` output 1: one-cycle pulse when a request is refused because the line is low.

## Operation
- Reset values: `drive_low`=0, `busy`=0, `read_enable`=0, `line_err`=0, state IDLE, all counters 0.
- Bit encoding, each bit 4 µs:
  - '0' = 3 µs low, then 1 µs released.
  - '1' = 1 µs low, then 3 µs released.
  - Stop bit = 1 µs low, then 2 µs released.
- States:
  - IDLE: a request is `start`=1, or an auto tick. If synced `line_in`=0 → pulse `line_err`, stay in IDLE. Otherwise load the shift register with `CMD_BYTE`, bit counter = 7, go to LOW.
  - LOW: `drive_low`=1 for 3 µs (current bit 0) or 1 µs (bit 1) → HIGH.
  - HIGH: `drive_low`=0 for the remainder of the 4 µs. Then if bit counter = 0 → STOP_LOW; else decrement, shift, and go to LOW.
  - STOP_LOW: `drive_low`=1 for 1 µs → STOP_HIGH.
  - STOP_HIGH: released for 2 µs → LISTEN.
  - LISTEN: `read_enable`=1 for `RESP_US` µs → IDLE.
- Timing counters:
  - The µs counter wraps at `US_CYCLES`−1.
  - The phase counter counts whole µs and clears on every state change.
- Requests outside IDLE are dropped, not queued.
- A request that coincides with an auto tick produces one transaction.
- Reset mid-transaction: `drive_low` drops asynchronously, releasing the line; `read_enable` drops; no partial frame resumes.

## Timing
- `drive_low` is registered. It rises on the cycle after the accepted request.
- Frame length is exactly 35 µs (8×4 + 3), i.e. 35·`US_CYCLES` cycles, from the first `drive_low` rise to the `read_enable` rise.
- `read_enable` is high for exactly `RESP_US`·`US_CYCLES` cycles.
- `busy` falls on the same edge as `read_enable`; a new request is accepted on the following cycle.
- The `line_err` decision uses the 2-flop synchronised value, so it has 2 cycles of latency relative to the pin.

## Configuration
- `N64_POLL_AUTO_EN` defined:
  - Compiles in a `POLL_US` period timer that free-runs from reset.
  - With `auto_en`=1, each timer expiry is a request.
  - A tick arriving while busy is dropped; the timer does not re-arm early.
- Macro undefined:
  - No timer logic is present.
  - `auto_en` is ignored; only `start` initiates a transaction.

## Structure
- Shared package `n64_pkg`:
  - State encoding enum.
  - Command constants: `N64_CMD_INFO`=8'h00, `N64_CMD_POLL`=8'h01.
  - Timing constants: `BIT_US`=4, `ZERO_LOW_US`=3, `ONE_LOW_US`=1, `STOP_LOW_US`=1, `STOP_HIGH_US`=2.
- Sub-module `n64_us_tick`: parameterised by `US_CYCLES`; emits a one-cycle pulse every µs. Shared with the reader.

## Test plan
Use `US_CYCLES`=4 and `RESP_US`=10 in simulation.
- `start` pulse, `line_in`=1, `CMD_BYTE`=0x01:
  - Bits 7..1: `drive_low` high 12 cycles / low 4, seven times.
  - Bit 0: high 4 / low 12.
  - Stop bit: high 4 / low 8.
  - `read_enable` rises 140 cycles after the first `drive_low` rise and stays high 40 cycles; `busy` then falls.
- `start` with `line_in`=0 held ≥3 cycles → `line_err` pulses 1 cycle; `drive_low` stays 0; `busy` stays 0.
- Second `start` during bit 3 → ignored; total frame still 140 cycles; no second frame.
- `reset` asserted during bit 5 while `drive_low`=1 → `drive_low` 0 in the same cycle (async); after release, outputs are at reset values and the next `start` produces a full frame.
- `CMD_BYTE`=0x00 → eight '0' bits (high 12 / low 4), then the stop bit.
- With `N64_POLL_AUTO_EN`, `POLL_US`=50, `auto_en`=1 → frames start every 200 cycles with no `start`; with `auto_en`=0 → no frames.

Source files
------------

// File: rtl/n64_pkg.sv
// Shared definitions for the N64 controller-line sender and reader:
// state encoding, command bytes and pulse-width timing in microseconds.
package n64_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOW,
    ST_HIGH,
    ST_STOP_LOW,
    ST_STOP_HIGH,
    ST_LISTEN
  } n64_state_e;

  localparam logic [7:0] N64_CMD_INFO = 8'h00;
  localparam logic [7:0] N64_CMD_POLL = 8'h01;

  localparam int BIT_US       = 4;
  localparam int ZERO_LOW_US  = 3;
  localparam int ONE_LOW_US   = 1;
  localparam int STOP_LOW_US  = 1;
  localparam int STOP_HIGH_US = 2;

  // Low time of a data bit; the released time is the rest of BIT_US.
  function automatic int low_us(input logic b);
    return b ? ONE_LOW_US : ZERO_LOW_US;
  endfunction

endpackage

// File: rtl/n64_us_tick.sv
// Microsecond strobe: one-cycle pulse every US_CYCLES clocks. The clr input
// realigns the count so a phase always starts on a whole-microsecond boundary.
module n64_us_tick #(
  parameter int US_CYCLES = 100
) (
  input  logic clock,
  input  logic reset,
  input  logic clr,
  output logic tick
);

  localparam int CW = $clog2(US_CYCLES);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == CW'(US_CYCLES - 1));

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clr || tick) cnt_d = '0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/n64_poll_sender.sv
// Console-side N64 command transmitter: sends CMD_BYTE plus stop bit with
// pulse-width encoding, then opens a response window for the reader.
// Optional periodic polling is compiled in with N64_POLL_AUTO_EN.
module n64_poll_sender
  import n64_pkg::*;
#(
  parameter int         US_CYCLES = 100,
  parameter logic [7:0] CMD_BYTE  = N64_CMD_POLL,
  parameter int         RESP_US   = 160,
  parameter int         POLL_US   = 16667
) (
  input  logic clock,
  input  logic reset,
  input  logic start,
  input  logic auto_en,
  input  logic line_in,
  output logic drive_low,
  output logic busy,
  output logic read_enable,
  output logic line_err
);

  localparam int PH_MAX = (RESP_US > BIT_US) ? RESP_US : BIT_US;
  localparam int PW     = $clog2(PH_MAX + 1);

  n64_state_e    state_q, state_d;
  logic [PW-1:0] phase_q, phase_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    sr_q, sr_d;
  logic          sync1_q, sync1_d, sync2_q, sync2_d;
  logic          drive_low_q, drive_low_d;
  logic          busy_q, busy_d;
  logic          read_enable_q, read_enable_d;
  logic          line_err_q, line_err_d;
  logic          us_tick, us_clr, req, phase_done;
  logic [PW-1:0] dur;

  n64_us_tick #(.US_CYCLES(US_CYCLES)) u_us_tick (
    .clock (clock),
    .reset (reset),
    .clr   (us_clr),
    .tick  (us_tick)
  );

`ifdef N64_POLL_AUTO_EN
  localparam int POLL_CYC = POLL_US * US_CYCLES;
  localparam int TW       = $clog2(POLL_CYC);

  logic [TW-1:0] poll_q, poll_d;
  logic          poll_tick;

  // Free-running period timer; ticks that land while busy are simply lost.
  assign poll_tick = (poll_q == TW'(POLL_CYC - 1));

  always_comb begin
    poll_d = poll_q + 1'b1;
    if (poll_tick) poll_d = '0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) poll_q <= '0;
    else       poll_q <= poll_d;
  end

  assign req = start | (auto_en & poll_tick);
`else
  logic          unused_auto_en;
  localparam int unused_poll_us = POLL_US;
  assign unused_auto_en = auto_en;
  assign req = start;
`endif

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      phase_q       <= '0;
      bit_q         <= '0;
      sr_q          <= '0;
      sync1_q       <= 1'b1;
      sync2_q       <= 1'b1;
      drive_low_q   <= 1'b0;
      busy_q        <= 1'b0;
      read_enable_q <= 1'b0;
      line_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      phase_q       <= phase_d;
      bit_q         <= bit_d;
      sr_q          <= sr_d;
      sync1_q       <= sync1_d;
      sync2_q       <= sync2_d;
      drive_low_q   <= drive_low_d;
      busy_q        <= busy_d;
      read_enable_q <= read_enable_d;
      line_err_q    <= line_err_d;
    end
  end

  // Length of the current phase in whole microseconds
  always_comb begin
    case (state_q)
      ST_LOW:       dur = PW'(low_us(sr_q[7]));
      ST_HIGH:      dur = PW'(BIT_US - low_us(sr_q[7]));
      ST_STOP_LOW:  dur = PW'(STOP_LOW_US);
      ST_STOP_HIGH: dur = PW'(STOP_HIGH_US);
      ST_LISTEN:    dur = PW'(RESP_US);
      default:      dur = PW'(1);
    endcase
  end

  assign phase_done = us_tick && (phase_q == dur - 1'b1);

  // Next-state and datapath
  always_comb begin
    state_d    = state_q;
    bit_d      = bit_q;
    sr_d       = sr_q;
    line_err_d = 1'b0;
    sync1_d    = line_in;
    sync2_d    = sync1_q;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          if (!sync2_q) begin
            line_err_d = 1'b1;
          end else begin
            sr_d    = CMD_BYTE;
            bit_d   = 3'd7;
            state_d = ST_LOW;
          end
        end
      end
      ST_LOW:       if (phase_done) state_d = ST_HIGH;
      ST_HIGH: begin
        if (phase_done) begin
          if (bit_q == 3'd0) begin
            state_d = ST_STOP_LOW;
          end else begin
            bit_d   = bit_q - 1'b1;
            sr_d    = {sr_q[6:0], 1'b0};
            state_d = ST_LOW;
          end
        end
      end
      ST_STOP_LOW:  if (phase_done) state_d = ST_STOP_HIGH;
      ST_STOP_HIGH: if (phase_done) state_d = ST_LISTEN;
      ST_LISTEN:    if (phase_done) state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase

    // Every phase starts with a fresh microsecond count.
    us_clr  = (state_q == ST_IDLE) || (state_d != state_q);
    phase_d = phase_q;
    if (state_d != state_q) phase_d = '0;
    else if (us_tick)       phase_d = phase_q + 1'b1;
  end

  // Outputs are registered from the next state so they align with it.
  always_comb begin
    drive_low_d   = (state_d == ST_LOW) || (state_d == ST_STOP_LOW);
    busy_d        = (state_d != ST_IDLE);
    read_enable_d = (state_d == ST_LISTEN);
  end

  assign drive_low   = drive_low_q;
  assign busy        = busy_q;
  assign read_enable = read_enable_q;
  assign line_err    = line_err_q;

endmodule

// File: tb/tb_n64_poll_sender.sv
// Bench for n64_poll_sender: two instances (commands 0x01 and 0x00) against a
// position-in-frame reference model, plus vector table and corner sequences.
module tb_n64_poll_sender;

  localparam int US       = 4;
  localparam int RESP     = 10;
  localparam int POLL     = 50;
  localparam int FRAME    = (35 + RESP) * US;
  localparam int POLL_CYC = POLL * US;
`ifdef N64_POLL_AUTO_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic clock = 1'b0, reset = 1'b1, start = 1'b0, auto_en = 1'b0, line_in = 1'b1;
  logic dl_a, busy_a, re_a, err_a, dl_b, busy_b, re_b, err_b;
  int   checks = 0, failures = 0;

  always #5 clock = ~clock;

  n64_poll_sender #(.US_CYCLES(US), .CMD_BYTE(8'h01), .RESP_US(RESP), .POLL_US(POLL)) dut_a (
    .clock(clock), .reset(reset), .start(start), .auto_en(auto_en), .line_in(line_in),
    .drive_low(dl_a), .busy(busy_a), .read_enable(re_a), .line_err(err_a));

  n64_poll_sender #(.US_CYCLES(US), .CMD_BYTE(8'h00), .RESP_US(RESP), .POLL_US(POLL)) dut_b (
    .clock(clock), .reset(reset), .start(start), .auto_en(auto_en), .line_in(line_in),
    .drive_low(dl_b), .busy(busy_b), .read_enable(re_b), .line_err(err_b));

  // ---------------- reference model ----------------
  int   m_pos[2];   // cycle index within the frame, -1 when idle
  logic m_err[2];
  logic m_s1, m_s2;
  int   m_edges;

  function automatic logic [7:0] cmd_of(input int d);
    return (d == 0) ? 8'h01 : 8'h00;
  endfunction

  // Expected {drive_low, read_enable, busy} at a given cycle of a frame.
  function automatic logic [2:0] exp_out(input logic [7:0] cmd, input int pos);
    int us, bi, lo;
    if (pos < 0) return 3'b000;
    us = pos / US;
    if (us < 32) begin
      bi = 7 - us / 4;
      lo = cmd[bi] ? 1 : 3;
      return {((us % 4) < lo), 1'b0, 1'b1};
    end
    if (us < 35) return {(us == 32), 1'b0, 1'b1};
    return 3'b011;
  endfunction

  task automatic model_reset();
    m_pos   = '{-1, -1};
    m_err   = '{1'b0, 1'b0};
    m_s1    = 1'b1;
    m_s2    = 1'b1;
    m_edges = 0;
  endtask

  task automatic model_step();
    logic req;
    m_edges++;
    req = start || (AUTO && auto_en && (m_edges % POLL_CYC == 0));
    for (int d = 0; d < 2; d++) begin
      m_err[d] = 1'b0;
      if (m_pos[d] >= 0) begin
        m_pos[d]++;
        if (m_pos[d] == FRAME) m_pos[d] = -1;
      end else if (req) begin
        if (m_s2) m_pos[d] = 0;
        else      m_err[d] = 1'b1;
      end
    end
    m_s2 = m_s1;
    m_s1 = line_in;
  endtask

  // ---------------- checking helpers ----------------
  task automatic chk_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b required=%b t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic compare();
    for (int d = 0; d < 2; d++) begin
      logic [2:0] e;
      logic [3:0] act;
      e   = exp_out(cmd_of(d), m_pos[d]);
      act = (d == 0) ? {dl_a, re_a, busy_a, err_a} : {dl_b, re_b, busy_b, err_b};
      chk_bit($sformatf("model_drive_low_%0d", d), act[3], e[2]);
      chk_bit($sformatf("model_read_enable_%0d", d), act[2], e[1]);
      chk_bit($sformatf("model_busy_%0d", d), act[1], e[0]);
      chk_bit($sformatf("model_line_err_%0d", d), act[0], m_err[d]);
    end
  endtask

  task automatic tick_and_check();
    @(posedge clock);
    if (reset) model_reset();
    else       model_step();
    @(negedge clock);
    compare();
  endtask

  // Start a frame on dut_a and time read_enable; optional extra start at cycle extra_at.
  task automatic frame_measure(input string tag, input int extra_at);
    int re_rise, re_fall;
    re_rise = -1;
    re_fall = -1;
    line_in = 1'b1;
    start   = 1'b1;
    tick_and_check();
    start   = 1'b0;
    chk_bit({tag, "_dl_rise"}, dl_a, 1'b1);
    for (int t = 1; t < 400 && re_fall < 0; t++) begin
      start = (t == extra_at);
      tick_and_check();
      if (re_a === 1'b1 && re_rise < 0) re_rise = t;
      if (re_a !== 1'b1 && re_rise >= 0 && re_fall < 0) re_fall = t;
    end
    start = 1'b0;
    chk_int({tag, "_re_rise_cycles"}, re_rise, 35 * US);
    chk_int({tag, "_re_len_cycles"}, re_fall - re_rise, RESP * US);
    chk_bit({tag, "_busy_after"}, busy_a, 1'b0);
  endtask

  typedef struct {
    logic start;
    logic line;
    int   n;
    logic dl_a;
    logic dl_b;
    logic re;
    logic busy;
    logic err;
  } vec_t;

  initial begin
    vec_t tbl[$];
    int   lowcnt, nb, prev;
    int   rises[$];

    // Vector table: one entry per microsecond of a full frame, then line error.
    tbl.push_back('{1'b0, 1'b1, 2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
    for (int us = 0; us < 35 + RESP; us++) begin
      vec_t v;
      v.start = (us == 0);
      v.line  = 1'b1;
      v.n     = US;
      v.err   = 1'b0;
      v.busy  = 1'b1;
      v.re    = (us >= 35);
      if (us < 28)      v.dl_a = (us % 4) < 3;
      else if (us < 32) v.dl_a = (us % 4) < 1;
      else              v.dl_a = (us == 32);
      if (us < 32)      v.dl_b = (us % 4) < 3;
      else              v.dl_b = (us == 32);
      tbl.push_back(v);
    end
    tbl.push_back('{1'b0, 1'b1, 4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1});
    tbl.push_back('{1'b0, 1'b1, 4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});

    model_reset();
    reset = 1'b1;
    repeat (3) tick_and_check();
    chk_bit("reset_drive_low", dl_a, 1'b0);
    chk_bit("reset_busy", busy_a, 1'b0);
    reset = 1'b0;

    foreach (tbl[i]) begin
      start   = tbl[i].start;
      line_in = tbl[i].line;
      for (int k = 0; k < tbl[i].n; k++) begin
        tick_and_check();
        if (k == 0) start = 1'b0;
        chk_bit($sformatf("vec%0d_drive_low_a", i), dl_a, tbl[i].dl_a);
        chk_bit($sformatf("vec%0d_drive_low_b", i), dl_b, tbl[i].dl_b);
        chk_bit($sformatf("vec%0d_read_enable", i), re_a, tbl[i].re);
        chk_bit($sformatf("vec%0d_busy", i), busy_a, tbl[i].busy);
        chk_bit($sformatf("vec%0d_line_err", i), err_a, tbl[i].err);
      end
    end

    // Second start during bit 3 is dropped; no follow-on frame.
    frame_measure("restart_bit3", 16 * US + 2);
    nb = 0;
    repeat (100) begin
      tick_and_check();
      nb += int'(busy_a);
    end
    chk_int("no_second_frame", nb, 0);

    // Asynchronous reset while driving bit 5 low.
    start = 1'b1;
    tick_and_check();
    start = 1'b0;
    repeat (34) tick_and_check();
    chk_bit("pre_reset_drive_low", dl_a, 1'b1);
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    chk_bit("async_reset_drive_low_a", dl_a, 1'b0);
    chk_bit("async_reset_drive_low_b", dl_b, 1'b0);
    chk_bit("async_reset_busy", busy_a, 1'b0);
    repeat (3) tick_and_check();
    reset = 1'b0;
    repeat (2) tick_and_check();
    frame_measure("after_reset", -1);

    // Randomized traffic against the model.
    lowcnt = 0;
    for (int c = 0; c < 3000; c++) begin
      if (c % 256 == 0) auto_en = 1'($urandom_range(0, 1));
      start = ($urandom_range(0, 29) == 0);
      if (lowcnt > 0) begin
        line_in = 1'b0;
        lowcnt--;
      end else begin
        line_in = 1'b1;
        if ($urandom_range(0, 39) == 0) lowcnt = $urandom_range(1, 6);
      end
      tick_and_check();
    end
    start   = 1'b0;
    line_in = 1'b1;

    // Periodic polling: frames every POLL_CYC cycles only when compiled in.
    reset = 1'b1;
    repeat (2) tick_and_check();
    reset   = 1'b0;
    auto_en = 1'b1;
    prev    = 0;
    for (int c = 1; c <= 700; c++) begin
      tick_and_check();
      if (busy_a === 1'b1 && prev == 0) rises.push_back(c);
      prev = int'(busy_a === 1'b1);
    end
    chk_int("auto_frame_count", rises.size(), AUTO ? 3 : 0);
    foreach (rises[i]) chk_int($sformatf("auto_frame%0d_start", i), rises[i], POLL_CYC * (i + 1));
    auto_en = 1'b0;
    nb = 0;
    prev = int'(busy_a === 1'b1);
    repeat (500) begin
      tick_and_check();
      if (busy_a === 1'b1 && prev == 0) nb++;
      prev = int'(busy_a === 1'b1);
    end
    chk_int("auto_disabled_frames", nb, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
